issue_window: RTL and testbench

- Parametrised in-order wait/issue buffer with an integrated register scoreboard for the dual-issue core.
- Sits between the 2-wide decode stage and the execution modules.
- Accepts up to 2 decoded instructions per cycle into a DEPTH-entry circular queue.
- Issues up to 2 per cycle from the head, in program order. An instruction issues only when none of its registers is busy and it does not conflict with its issue partner.
- Tracks outstanding destinations and clears them on writeback. Supports a pipeline flush.

---
 rtl/issue_window.sv | 156 +++++++++++++++
 tb/tb_issue_window.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_window.sv
// In-order two-wide wait/issue queue with a register scoreboard: holds decoded
// instructions until their operands and destination are free, then issues from the head.
module issue_window #(
   parameter int DEPTH = 4,
   parameter int PW    = 67,
   parameter int NREG  = 64,
   parameter int WB_N  = 2,
   localparam int RW   = $clog2(NREG),
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 flush,
   input  logic [1:0]           in_vld,
   input  logic [2*PW-1:0]      in_pay,
   input  logic [2*RW-1:0]      in_ds,
   input  logic [2*RW-1:0]      in_dt,
   input  logic [2*RW-1:0]      in_dd,
   output logic                 in_rdy,
   output logic [1:0]           out_vld,
   output logic [2*PW-1:0]      out_pay,
   output logic [2*RW-1:0]      out_dd,
   input  logic                 out_rdy,
   input  logic [WB_N-1:0]      wb_en,
   input  logic [WB_N*RW-1:0]   wb_reg,
   output logic [NREG-1:0]      board,
   output logic [CW-1:0]        count
);

   logic [PW-1:0]   pay_q [DEPTH];
   logic [PW-1:0]   pay_d [DEPTH];
   logic [RW-1:0]   ds_q  [DEPTH];
   logic [RW-1:0]   ds_d  [DEPTH];
   logic [RW-1:0]   dt_q  [DEPTH];
   logic [RW-1:0]   dt_d  [DEPTH];
   logic [RW-1:0]   dd_q  [DEPTH];
   logic [RW-1:0]   dd_d  [DEPTH];

   logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic [NREG-1:0] board_q, board_d;

   logic [AW-1:0]   h1, slot1;
   logic            v0, v1, clash1;
   logic            enq;
   logic [1:0]      n_enq, n_deq, deq_vld;
   logic [NREG-1:0] set_mask, clr_mask;

   // r0 and f0 are hard-wired constants and never carry a dependency.
   function automatic logic tracked(input logic [RW-1:0] r);
      return (r != '0) && (r != RW'(NREG / 2));
   endfunction

   function automatic logic busy(input logic [NREG-1:0] b, input logic [RW-1:0] r);
      return tracked(r) && b[r];
   endfunction

   function automatic logic [1:0] popcnt2(input logic [1:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]};
   endfunction

   assign h1 = head_q + AW'(1);

   always_comb begin
      v0 = (count_q != '0)
         && !busy(board_q, ds_q[head_q])
         && !busy(board_q, dt_q[head_q])
         && !busy(board_q, dd_q[head_q]);
      clash1 = tracked(dd_q[head_q])
         && ((ds_q[h1] == dd_q[head_q]) || (dt_q[h1] == dd_q[head_q]) || (dd_q[h1] == dd_q[head_q]));
      v1 = v0 && (count_q >= CW'(2))
         && !busy(board_q, ds_q[h1])
         && !busy(board_q, dt_q[h1])
         && !busy(board_q, dd_q[h1])
         && !clash1;
   end

   assign out_vld = {v1, v0};
   assign out_pay = {pay_q[h1], pay_q[head_q]};
   assign out_dd  = {dd_q[h1], dd_q[head_q]};
   assign in_rdy  = (count_q <= CW'(DEPTH - 2));
   assign board   = board_q;
   assign count   = count_q;

   // Valid lanes are compacted: lane 1 lands right after lane 0 only if lane 0 was valid.
   assign slot1 = tail_q + AW'(in_vld[0]);

   always_comb begin
      pay_d    = pay_q;
      ds_d     = ds_q;
      dt_d     = dt_q;
      dd_d     = dd_q;
      enq      = in_rdy && !flush;
      n_enq    = enq ? popcnt2(in_vld) : 2'd0;
      deq_vld  = out_rdy ? out_vld : 2'b00;
      n_deq    = popcnt2(deq_vld);

      if (enq && in_vld[0]) begin
         pay_d[tail_q] = in_pay[0 +: PW];
         ds_d[tail_q]  = in_ds[0 +: RW];
         dt_d[tail_q]  = in_dt[0 +: RW];
         dd_d[tail_q]  = in_dd[0 +: RW];
      end
      if (enq && in_vld[1]) begin
         pay_d[slot1] = in_pay[PW +: PW];
         ds_d[slot1]  = in_ds[RW +: RW];
         dt_d[slot1]  = in_dt[RW +: RW];
         dd_d[slot1]  = in_dd[RW +: RW];
      end

      head_d  = head_q + AW'(n_deq);
      tail_d  = tail_q + AW'(n_enq);
      count_d = count_q + CW'(n_enq) - CW'(n_deq);
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end

      // A producer issuing on the same edge as a writeback to its register stays outstanding.
      clr_mask = '0;
      for (int w = 0; w < WB_N; w++) begin
         if (wb_en[w] && tracked(wb_reg[w*RW +: RW]))
            clr_mask[wb_reg[w*RW +: RW]] = 1'b1;
      end
      set_mask = '0;
      for (int k = 0; k < 2; k++) begin
         if (deq_vld[k] && tracked(out_dd[k*RW +: RW]))
            set_mask[out_dd[k*RW +: RW]] = 1'b1;
      end
      board_d = (board_q & ~clr_mask) | set_mask;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         board_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         board_q <= board_d;
      end
   end

   always_ff @(posedge clk) begin
      pay_q <= pay_d;
      ds_q  <= ds_d;
      dt_q  <= dt_d;
      dd_q  <= dd_d;
   end

endmodule

// File: tb/tb_issue_window.sv
// Bench for issue_window: scoreboard of issued payloads plus per-scenario timing and board checks.
module tb_issue_window;
   localparam int DEPTH = 4;
   localparam int PW    = 67;
   localparam int NREG  = 64;
   localparam int WB_N  = 2;
   localparam int RW    = 6;
   localparam int CW    = 3;

   logic                clk = 1'b0;
   logic                rstn;
   logic                flush;
   logic [1:0]          in_vld;
   logic [2*PW-1:0]     in_pay;
   logic [2*RW-1:0]     in_ds, in_dt, in_dd;
   logic                in_rdy;
   logic [1:0]          out_vld;
   logic [2*PW-1:0]     out_pay;
   logic [2*RW-1:0]     out_dd;
   logic                out_rdy;
   logic [WB_N-1:0]     wb_en;
   logic [WB_N*RW-1:0]  wb_reg;
   logic [NREG-1:0]     board;
   logic [CW-1:0]       count;

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct packed {
      logic [PW-1:0] pay;
      logic [RW-1:0] dd;
   } exp_t;
   exp_t exp_q[$];

   issue_window #(.DEPTH(DEPTH), .PW(PW), .NREG(NREG), .WB_N(WB_N)) dut (
      .clk(clk), .rstn(rstn), .flush(flush),
      .in_vld(in_vld), .in_pay(in_pay), .in_ds(in_ds), .in_dt(in_dt), .in_dd(in_dd),
      .in_rdy(in_rdy), .out_vld(out_vld), .out_pay(out_pay), .out_dd(out_dd),
      .out_rdy(out_rdy), .wb_en(wb_en), .wb_reg(wb_reg), .board(board), .count(count)
   );

   always #5 clk = ~clk;

   function automatic logic [PW-1:0] mk(input logic [31:0] n);
      return {3'b101, n ^ 32'hA5A5_0000, n};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int k, input logic [PW-1:0] p,
                           input logic [RW-1:0] ds, input logic [RW-1:0] dt, input logic [RW-1:0] dd);
      in_pay[k*PW +: PW] = p;
      in_ds[k*RW +: RW]  = ds;
      in_dt[k*RW +: RW]  = dt;
      in_dd[k*RW +: RW]  = dd;
   endtask

   task automatic push(input logic [PW-1:0] p, input logic [RW-1:0] dd);
      exp_q.push_back('{pay: p, dd: dd});
   endtask

   // Every accepted issue slot must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rstn === 1'b1 && out_rdy === 1'b1) begin
         for (int k = 0; k < 2; k++) begin
            if (out_vld[k] === 1'b1) begin
               tests_run++;
               if (exp_q.size() == 0) begin
                  tests_failed++;
                  $display("FAIL sb_underflow slot%0d: got pay=%h dd=%0d, expected no issue",
                           k, out_pay[k*PW +: PW], out_dd[k*RW +: RW]);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  if (out_pay[k*PW +: PW] !== e.pay || out_dd[k*RW +: RW] !== e.dd) begin
                     tests_failed++;
                     $display("FAIL sb_issue slot%0d: got pay=%h dd=%0d, want pay=%h dd=%0d",
                              k, out_pay[k*PW +: PW], out_dd[k*RW +: RW], e.pay, e.dd);
                  end
               end
            end
         end
      end
   end

   task automatic test_reset();
      rstn = 1'b0; flush = 1'b0; in_vld = '0; in_pay = '0; in_ds = '0; in_dt = '0; in_dd = '0;
      out_rdy = 1'b0; wb_en = '0; wb_reg = '0;
      #12;
      tests_run++;
      if (count !== 3'd0 || board !== 64'h0 || out_vld !== 2'b00 || in_rdy !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_state: got count=%0d board=%h out_vld=%b in_rdy=%b, want 0 0 00 1",
                  count, board, out_vld, in_rdy);
      end
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      out_rdy = 1'b1;
      set_lane(0, mk(1), 6'd1, 6'd0, 6'd3);
      set_lane(1, mk(2), 6'd2, 6'd0, 6'd4);
      in_vld = 2'b11;
      push(mk(1), 6'd3); push(mk(2), 6'd4);
      #2;
      tests_run++;
      if (out_vld !== 2'b00) begin
         tests_failed++; $display("FAIL basic_no_bypass: got out_vld=%b want 00", out_vld);
      end
      tick();
      in_vld = '0;
      #2;
      tests_run++;
      if (out_vld !== 2'b11 || count !== 3'd2) begin
         tests_failed++; $display("FAIL basic_issue: got out_vld=%b count=%0d want 11 2", out_vld, count);
      end
      tick();
      #2;
      tests_run++;
      if (board !== 64'h18 || count !== 3'd0) begin
         tests_failed++; $display("FAIL basic_board: got board=%h count=%0d want 18 0", board, count);
      end
      wb_en = 2'b11; wb_reg = {6'd4, 6'd3};
      tick();
      wb_en = '0;
      #2;
      tests_run++;
      if (board !== 64'h0) begin
         tests_failed++; $display("FAIL basic_wb_clear: got board=%h want 0", board);
      end
      tick();
   endtask

   task automatic test_raw();
      out_rdy = 1'b1;
      set_lane(0, mk(10), 6'd0, 6'd0, 6'd5);
      set_lane(1, mk(11), 6'd5, 6'd0, 6'd6);
      in_vld = 2'b11;
      push(mk(10), 6'd5); push(mk(11), 6'd6);
      tick();
      in_vld = '0;
      #2;
      tests_run++;
      if (out_vld !== 2'b01) begin
         tests_failed++; $display("FAIL raw_partner: got out_vld=%b want 01", out_vld);
      end
      tick();
      #2;
      tests_run++;
      if (out_vld !== 2'b00 || board !== 64'h20) begin
         tests_failed++; $display("FAIL raw_blocked: got out_vld=%b board=%h want 00 20", out_vld, board);
      end
      tick();
      #2;
      wb_en = 2'b01; wb_reg = {6'd0, 6'd5};
      #1;
      tests_run++;
      if (out_vld !== 2'b00) begin
         tests_failed++; $display("FAIL raw_same_cycle_wb: got out_vld=%b want 00", out_vld);
      end
      tick();
      wb_en = '0;
      #2;
      tests_run++;
      if (out_vld !== 2'b01) begin
         tests_failed++; $display("FAIL raw_after_wb: got out_vld=%b want 01", out_vld);
      end
      tick();
      #2;
      tests_run++;
      if (board !== 64'h40 || count !== 3'd0) begin
         tests_failed++; $display("FAIL raw_board: got board=%h count=%0d want 40 0", board, count);
      end
      wb_en = 2'b10; wb_reg = {6'd6, 6'd0};
      tick();
      wb_en = '0;
      #2;
      tests_run++;
      if (board !== 64'h0) begin
         tests_failed++; $display("FAIL raw_wb_port1: got board=%h want 0", board);
      end
      tick();
   endtask

   task automatic test_full_wrap();
      out_rdy = 1'b0;
      set_lane(0, mk(20), 6'd0, 6'd0, 6'd0);
      set_lane(1, mk(21), 6'd0, 6'd0, 6'd0);
      in_vld = 2'b11;
      push(mk(20), 6'd0); push(mk(21), 6'd0);
      tick();
      set_lane(0, mk(22), 6'd0, 6'd0, 6'd0);
      set_lane(1, mk(23), 6'd0, 6'd0, 6'd0);
      push(mk(22), 6'd0); push(mk(23), 6'd0);
      #2;
      tests_run++;
      if (count !== 3'd2 || in_rdy !== 1'b1) begin
         tests_failed++; $display("FAIL full_half: got count=%0d in_rdy=%b want 2 1", count, in_rdy);
      end
      tick();
      set_lane(0, mk(24), 6'd0, 6'd0, 6'd0);
      set_lane(1, mk(25), 6'd0, 6'd0, 6'd0);
      #2;
      tests_run++;
      if (count !== 3'd4 || in_rdy !== 1'b0 || out_vld !== 2'b11) begin
         tests_failed++;
         $display("FAIL full_state: got count=%0d in_rdy=%b out_vld=%b want 4 0 11", count, in_rdy, out_vld);
      end
      tick();
      in_vld = '0;
      #2;
      tests_run++;
      if (count !== 3'd4) begin
         tests_failed++; $display("FAIL full_ignore: got count=%0d want 4", count);
      end
      out_rdy = 1'b1;
      tick();
      #2;
      tests_run++;
      if (count !== 3'd2) begin
         tests_failed++; $display("FAIL full_drain1: got count=%0d want 2", count);
      end
      tick();
      #2;
      tests_run++;
      if (count !== 3'd0) begin
         tests_failed++; $display("FAIL full_drain2: got count=%0d want 0", count);
      end
      for (int i = 0; i < 10; i++) begin
         set_lane(0, mk(32'(100 + 2*i)), 6'd0, 6'd0, (i % 2 == 1) ? 6'd32 : 6'd0);
         set_lane(1, mk(32'(101 + 2*i)), 6'd0, 6'd0, (i % 2 == 1) ? 6'd0 : 6'd32);
         push(mk(32'(100 + 2*i)), (i % 2 == 1) ? 6'd32 : 6'd0);
         push(mk(32'(101 + 2*i)), (i % 2 == 1) ? 6'd0 : 6'd32);
         in_vld = 2'b11;
         #1;
         tests_run++;
         if (in_rdy !== 1'b1) begin
            tests_failed++; $display("FAIL wrap_rdy%0d: got in_rdy=%b want 1", i, in_rdy);
         end
         tick();
      end
      in_vld = '0;
      tick();
      tick();
      #2;
      tests_run++;
      if (count !== 3'd0 || exp_q.size() != 0 || board !== 64'h0) begin
         tests_failed++;
         $display("FAIL wrap_drained: got count=%0d pending=%0d board=%h want 0 0 0", count, exp_q.size(), board);
      end
      tick();
   endtask

   task automatic test_single_lane();
      out_rdy = 1'b0;
      set_lane(0, mk(50), 6'd12, 6'd13, 6'd14);
      set_lane(1, {3'b011, 64'hDEAD_BEEF_0123_4567}, 6'd0, 6'd0, 6'd0);
      in_vld = 2'b10;
      push({3'b011, 64'hDEAD_BEEF_0123_4567}, 6'd0);
      tick();
      set_lane(0, {3'b110, 64'h0F1E_2D3C_4B5A_6978}, 6'd0, 6'd0, 6'd0);
      set_lane(1, mk(53), 6'd12, 6'd13, 6'd14);
      in_vld = 2'b01;
      push({3'b110, 64'h0F1E_2D3C_4B5A_6978}, 6'd0);
      #2;
      tests_run++;
      if (count !== 3'd1 || out_vld !== 2'b01) begin
         tests_failed++; $display("FAIL lane_hi_only: got count=%0d out_vld=%b want 1 01", count, out_vld);
      end
      tick();
      in_vld = '0;
      #2;
      tests_run++;
      if (count !== 3'd2 || out_vld !== 2'b11 ||
          out_pay !== {3'b110, 64'h0F1E_2D3C_4B5A_6978, 3'b011, 64'hDEAD_BEEF_0123_4567}) begin
         tests_failed++;
         $display("FAIL lane_compact: got count=%0d out_vld=%b out_pay=%h", count, out_vld, out_pay);
      end
      out_rdy = 1'b1;
      tick();
      #2;
      tests_run++;
      if (count !== 3'd0) begin
         tests_failed++; $display("FAIL lane_drain: got count=%0d want 0", count);
      end
      tick();
   endtask

   task automatic test_set_wins();
      out_rdy = 1'b1;
      set_lane(0, mk(70), 6'd0, 6'd0, 6'd7);
      in_vld = 2'b01;
      push(mk(70), 6'd7);
      tick();
      in_vld = '0;
      wb_en = 2'b01; wb_reg = {6'd0, 6'd7};
      #2;
      tests_run++;
      if (out_vld !== 2'b01) begin
         tests_failed++; $display("FAIL setwins_issue: got out_vld=%b want 01", out_vld);
      end
      tick();
      wb_en = '0;
      #2;
      tests_run++;
      if (board !== 64'h80) begin
         tests_failed++; $display("FAIL setwins_board: got board=%h want 80", board);
      end
      set_lane(0, mk(71), 6'd32, 6'd0, 6'd0);
      set_lane(1, mk(72), 6'd0, 6'd32, 6'd32);
      in_vld = 2'b11;
      push(mk(71), 6'd0); push(mk(72), 6'd32);
      tick();
      in_vld = '0;
      wb_en = 2'b11; wb_reg = {6'd32, 6'd0};
      #2;
      tests_run++;
      if (out_vld !== 2'b11) begin
         tests_failed++; $display("FAIL untracked_noblock: got out_vld=%b want 11", out_vld);
      end
      tick();
      wb_en = '0;
      #2;
      tests_run++;
      if (board !== 64'h80) begin
         tests_failed++; $display("FAIL untracked_board: got board=%h want 80", board);
      end
      wb_en = 2'b10; wb_reg = {6'd7, 6'd0};
      tick();
      wb_en = '0;
      #2;
      tests_run++;
      if (board !== 64'h0) begin
         tests_failed++; $display("FAIL setwins_clear: got board=%h want 0", board);
      end
      tick();
   endtask

   task automatic test_flush_reset();
      out_rdy = 1'b1;
      set_lane(0, mk(60), 6'd0, 6'd0, 6'd9);
      in_vld = 2'b01;
      push(mk(60), 6'd9);
      tick();
      in_vld = '0;
      tick();
      out_rdy = 1'b0;
      #2;
      tests_run++;
      if (board !== 64'h200) begin
         tests_failed++; $display("FAIL flush_pre_board: got board=%h want 200", board);
      end
      set_lane(0, mk(61), 6'd0, 6'd0, 6'd0);
      set_lane(1, mk(62), 6'd0, 6'd0, 6'd10);
      in_vld = 2'b11;
      push(mk(61), 6'd0); push(mk(62), 6'd10);
      tick();
      set_lane(0, mk(63), 6'd0, 6'd0, 6'd0);
      in_vld = 2'b01;
      push(mk(63), 6'd0);
      tick();
      in_vld = '0;
      #2;
      tests_run++;
      if (count !== 3'd3) begin
         tests_failed++; $display("FAIL flush_fill: got count=%0d want 3", count);
      end
      flush = 1'b1;
      set_lane(0, mk(64), 6'd0, 6'd0, 6'd0);
      set_lane(1, mk(65), 6'd0, 6'd0, 6'd0);
      in_vld = 2'b11;
      out_rdy = 1'b1;
      #1;
      tests_run++;
      if (out_vld !== 2'b11) begin
         tests_failed++; $display("FAIL flush_issue: got out_vld=%b want 11", out_vld);
      end
      tick();
      flush = 1'b0;
      in_vld = '0;
      void'(exp_q.pop_back());
      #2;
      tests_run++;
      if (count !== 3'd0 || out_vld !== 2'b00 || board !== 64'h600) begin
         tests_failed++;
         $display("FAIL flush_state: got count=%0d out_vld=%b board=%h want 0 00 600", count, out_vld, board);
      end
      tick();
      #2;
      tests_run++;
      if (count !== 3'd0 || out_vld !== 2'b00) begin
         tests_failed++; $display("FAIL flush_dropped: got count=%0d out_vld=%b want 0 00", count, out_vld);
      end
      out_rdy = 1'b0;
      set_lane(0, mk(66), 6'd0, 6'd0, 6'd0);
      in_vld = 2'b01;
      tick();
      in_vld = '0;
      #2;
      tests_run++;
      if (out_vld !== 2'b01) begin
         tests_failed++; $display("FAIL prereset_vld: got out_vld=%b want 01", out_vld);
      end
      rstn = 1'b0;
      #1;
      tests_run++;
      if (board !== 64'h0 || out_vld !== 2'b00 || count !== 3'd0 || in_rdy !== 1'b1) begin
         tests_failed++;
         $display("FAIL async_reset: got board=%h out_vld=%b count=%0d in_rdy=%b want 0 00 0 1",
                  board, out_vld, count, in_rdy);
      end
      #1;
      rstn = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_raw();
      test_full_wrap();
      test_single_lane();
      test_set_wins();
      test_flush_reset();
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++; $display("FAIL sb_leftover: got %0d pending issues want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
